// File: rtl/vadd_arb.sv
// Two-requester round-robin arbiter feeding a lane-wise modular vector adder
// with a fixed-latency result pipeline and per-requester acceptance counters.
module vadd_arb #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LANES = 4,
    parameter int unsigned LAT   = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [LANES*WIDTH-1:0] a0,
    input  logic [LANES*WIDTH-1:0] b0,
    input  logic                   v0,
    output logic                   r0,
    input  logic [LANES*WIDTH-1:0] a1,
    input  logic [LANES*WIDTH-1:0] b1,
    input  logic                   v1,
    output logic                   r1,
    input  logic                   hold,
    output logic [LANES*WIDTH-1:0] y,
    output logic                   y_valid,
    output logic                   y_id,
    output logic [15:0]            cnt0,
    output logic [15:0]            cnt1,
    output logic                   busy
);

    localparam int unsigned VW = LANES * WIDTH;

    // ptr_q holds the index of the last accepted requester; reset to 1 so
    // requester 0 wins the first contention.
    logic           ptr_q, ptr_d;
    logic [15:0]    cnt0_q, cnt0_d;
    logic [15:0]    cnt1_q, cnt1_d;
    logic [VW-1:0]  data_q [LAT];
    logic [VW-1:0]  data_d [LAT];
    logic [LAT-1:0] id_q, id_d;
    logic [LAT-1:0] vld_q, vld_d;

    logic           gnt0, gnt1, acc;
    logic [VW-1:0]  opa, opb, sum;

    always_comb begin
        gnt0 = !reset && !hold && v0 && (!v1 || ptr_q);
        gnt1 = !reset && !hold && v1 && (!v0 || !ptr_q);
        acc  = gnt0 || gnt1;
        opa  = gnt1 ? a1 : a0;
        opb  = gnt1 ? b1 : b0;
        sum  = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            sum[i*WIDTH +: WIDTH] = opa[i*WIDTH +: WIDTH] + opb[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        ptr_d  = ptr_q;
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        data_d = data_q;
        id_d   = id_q;
        vld_d  = '0;

        if (gnt0) begin
            ptr_d = 1'b0;
            if (cnt0_q != '1) cnt0_d = cnt0_q + 16'd1;
        end
        if (gnt1) begin
            ptr_d = 1'b1;
            if (cnt1_q != '1) cnt1_d = cnt1_q + 16'd1;
        end

        // Data registers load only behind a valid, so the last stage keeps
        // the most recent result on y while y_valid is low.
        vld_d[0] = acc;
        if (acc) begin
            data_d[0] = sum;
            id_d[0]   = gnt1;
        end
        for (int unsigned s = 1; s < LAT; s++) begin
            vld_d[s] = vld_q[s-1];
            if (vld_q[s-1]) begin
                data_d[s] = data_q[s-1];
                id_d[s]   = id_q[s-1];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q  <= 1'b1;
            cnt0_q <= '0;
            cnt1_q <= '0;
            data_q <= '{default: '0};
            id_q   <= '0;
            vld_q  <= '0;
        end else begin
            ptr_q  <= ptr_d;
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
            data_q <= data_d;
            id_q   <= id_d;
            vld_q  <= vld_d;
        end
    end

    assign r0      = gnt0;
    assign r1      = gnt1;
    assign y       = data_q[LAT-1];
    assign y_id    = id_q[LAT-1];
    assign y_valid = vld_q[LAT-1];
    assign busy    = |vld_q;
    assign cnt0    = cnt0_q;
    assign cnt1    = cnt1_q;

endmodule
